// File: rtl/fft_sample_sequencer.sv
// Store-side sequencer for the FFT: LOAD streams NUM_SAMPLES store words out on a valid/ready
// stream, STORE writes NUM_SAMPLES FFT results back into the store in order.
module fft_sample_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int NUM_SAMPLES = 1024,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_store,
  output logic              busy,
  output logic              done,
  output logic              st_read_enable,
  output logic              st_write_enable,
  output logic              st_start_write,
  output logic              st_end_write,
  output logic [ADDR_W-1:0] st_address,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [DATA_W-1:0] st_rdata,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              smp_last,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic              res_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_DRAIN,
    S_WR_OPEN,
    S_WR_DATA,
    S_WR_CLOSE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [DATA_W-1:0]   smp_data_q, smp_data_d;
  logic                smp_valid_q, smp_valid_d;
  logic                smp_last_q, smp_last_d;
  logic                done_q, done_d;
  logic                smp_hs;

  assign smp_hs = smp_valid_q & smp_ready;

  always_comb begin
    state_d         = state_q;
    rd_cnt_d        = rd_cnt_q;
    wr_cnt_d        = wr_cnt_q;
    smp_data_d      = smp_data_q;
    smp_valid_d     = smp_valid_q;
    smp_last_d      = smp_last_q;
    done_d          = 1'b0;
    st_read_enable  = 1'b0;
    st_write_enable = 1'b0;
    st_start_write  = 1'b0;
    st_end_write    = 1'b0;
    st_address      = '0;
    st_wdata        = '0;
    res_ready       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_d  = S_LOAD;
          rd_cnt_d = '0;
        end else if (start_store) begin
          state_d  = S_WR_OPEN;
          wr_cnt_d = '0;
        end
      end
      S_LOAD: begin
        // A read is issued only when the output register is free or being emptied this cycle.
        if (!smp_valid_q || smp_ready) begin
          st_read_enable = 1'b1;
          st_address     = BASE + rd_cnt_q;
          smp_data_d     = st_rdata;
          smp_valid_d    = 1'b1;
          smp_last_d     = (rd_cnt_q == LAST_IDX);
          if (rd_cnt_q == LAST_IDX) begin
            state_d  = S_LOAD_DRAIN;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + ADDR_W'(1);
          end
        end
      end
      S_LOAD_DRAIN: begin
        // Only the final beat can be pending here.
        if (smp_hs) begin
          smp_valid_d = 1'b0;
          smp_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WR_OPEN: begin
        st_start_write = 1'b1;
        state_d        = S_WR_DATA;
      end
      S_WR_DATA: begin
        res_ready = 1'b1;
        if (res_valid) begin
          st_write_enable = 1'b1;
          st_address      = BASE + wr_cnt_q;
          st_wdata        = res_data;
          if (wr_cnt_q == LAST_IDX) begin
            state_d  = S_WR_CLOSE;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          end
        end
      end
      S_WR_CLOSE: begin
        st_end_write = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      smp_data_q  <= '0;
      smp_valid_q <= 1'b0;
      smp_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      smp_data_q  <= smp_data_d;
      smp_valid_q <= smp_valid_d;
      smp_last_q  <= smp_last_d;
      done_q      <= done_d;
    end
  end

  // LOAD completion is flagged the cycle after the last handshake; STORE completes with end_write.
  assign done      = done_q | (state_q == S_WR_CLOSE);
  assign busy      = (state_q != S_IDLE);
  assign smp_data  = smp_data_q;
  assign smp_valid = smp_valid_q;
  assign smp_last  = smp_last_q;

endmodule

// File: tb/tb_fft_sample_sequencer.sv
// Bench for fft_sample_sequencer: a default instance (1024 samples at base 0) and a small
// wrapping instance (4 samples at base 1022), both checked against a plain store model.
module tb_fft_sample_sequencer;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int N  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_load = 0, start_store = 0;
  logic busy, done, st_read_enable, st_write_enable, st_start_write, st_end_write;
  logic [AW-1:0] st_address;
  logic [DW-1:0] st_wdata, st_rdata, smp_data, res_data;
  logic smp_valid, smp_ready, smp_last, res_valid, res_ready;

  logic start_load6 = 0;
  logic busy6, done6, re6, we6, sw6, ew6, smp_valid6, smp_last6, res_ready6;
  logic [AW-1:0] addr6;
  logic [DW-1:0] wdata6, rdata6, smp_data6;

  logic [DW-1:0] mem [0:N-1];
  assign st_rdata = st_read_enable ? mem[st_address] : '0;
  assign rdata6   = re6 ? mem[addr6] : '0;

  fft_sample_sequencer dut (
    .clk(clk), .rst(rst), .start_load(start_load), .start_store(start_store),
    .busy(busy), .done(done), .st_read_enable(st_read_enable),
    .st_write_enable(st_write_enable), .st_start_write(st_start_write),
    .st_end_write(st_end_write), .st_address(st_address), .st_wdata(st_wdata),
    .st_rdata(st_rdata), .smp_data(smp_data), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .smp_last(smp_last), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  fft_sample_sequencer #(.DATA_W(DW), .ADDR_W(AW), .NUM_SAMPLES(4), .BASE_ADDR(1022)) dut6 (
    .clk(clk), .rst(rst), .start_load(start_load6), .start_store(1'b0),
    .busy(busy6), .done(done6), .st_read_enable(re6), .st_write_enable(we6),
    .st_start_write(sw6), .st_end_write(ew6), .st_address(addr6), .st_wdata(wdata6),
    .st_rdata(rdata6), .smp_data(smp_data6), .smp_valid(smp_valid6),
    .smp_ready(smp_ready), .smp_last(smp_last6), .res_data(16'h0),
    .res_valid(1'b0), .res_ready(res_ready6)
  );

  int total = 0;
  int bad   = 0;

  // Input drivers: 0 = always ready, 1 = toggle, 2 = random. res: 0 off, 1 random, 2 always.
  int rdy_mode = 0;
  int res_mode = 0;
  int n_res_hs = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       smp_ready = 1'b1;
      1:       smp_ready = ~smp_ready;
      default: smp_ready = 1'($urandom % 2);
    endcase
    res_valid = (res_mode == 2) ? 1'b1 : (res_mode == 1) ? 1'($urandom % 2) : 1'b0;
    res_data  = 16'hA000 + 16'(n_res_hs);
  end
  initial smp_ready = 1'b0;

  // Observation of the main instance at the falling edge.
  int cyc = 0;
  int rd_q[$], wa_q[$], wd_q[$], bd_q[$];
  bit bl_q[$];
  int n_start, n_end, n_done, n_done_end, n_excl, n_idle, n_unstable;
  int first_hs, last_hs, done_cyc, busy_rise;
  bit prev_busy = 0, prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  int rd6_q[$], bd6_q[$];
  bit bl6_q[$];
  int n_done6;

  always @(negedge clk) begin
    cyc++;
    if (st_read_enable) rd_q.push_back(int'(st_address));
    if (st_write_enable) begin
      wa_q.push_back(int'(st_address));
      wd_q.push_back(int'(st_wdata));
    end
    if (st_start_write) n_start++;
    if (st_end_write) n_end++;
    if (smp_valid && smp_ready) begin
      if (bd_q.size() == 0) first_hs = cyc;
      last_hs = cyc;
      bd_q.push_back(int'(smp_data));
      bl_q.push_back(smp_last);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      if (st_end_write) n_done_end++;
    end
    if (busy && !prev_busy) busy_rise = cyc;
    prev_busy = busy;
    if (prev_stall && (!smp_valid || smp_data !== prev_data || smp_last !== prev_last)) n_unstable++;
    prev_stall = smp_valid && !smp_ready;
    prev_data  = smp_data;
    prev_last  = smp_last;
    if (int'(st_read_enable) + int'(st_write_enable) + int'(st_start_write) + int'(st_end_write) > 1)
      n_excl++;
    if (!(st_read_enable || st_write_enable || st_start_write || st_end_write) &&
        (st_address != 0 || st_wdata != 0)) n_idle++;
    if (res_valid && res_ready) n_res_hs++;
    if (re6) rd6_q.push_back(int'(addr6));
    if (smp_valid6 && smp_ready) begin
      bd6_q.push_back(int'(smp_data6));
      bl6_q.push_back(smp_last6);
    end
    if (done6) n_done6++;
  end

  task automatic clear_mon();
    rd_q.delete(); wa_q.delete(); wd_q.delete(); bd_q.delete(); bl_q.delete();
    rd6_q.delete(); bd6_q.delete(); bl6_q.delete();
    n_start = 0; n_end = 0; n_done = 0; n_done_end = 0; n_excl = 0; n_idle = 0;
    n_unstable = 0; n_res_hs = 0; n_done6 = 0;
    first_hs = 0; last_hs = 0; done_cyc = 0; busy_rise = 0;
  endtask

  task automatic pulse(input bit ld, input bit st, input bit ld6);
    @(posedge clk); #1;
    start_load = ld; start_store = st; start_load6 = ld6;
    @(posedge clk); #1;
    start_load = 0; start_store = 0; start_load6 = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    total++;
    if (n_done == 0) begin
      bad++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, budget);
    end
  endtask

  // Reference: LOAD beat i carries mem[(base+i) mod 2^AW]; STORE write i goes to that address.
  function automatic int exp_addr(input int base, input int i);
    return (base + i) % (1 << AW);
  endfunction

  task automatic check_load_beats(input string name, input int base, input int cnt);
    int err_d, err_l, err_a;
    total++;
    if (bd_q.size() != cnt || rd_q.size() != cnt) begin
      bad++;
      $display("FAIL %s count: beats=%0d reads=%0d expected %0d", name, bd_q.size(), rd_q.size(), cnt);
    end
    err_d = 0; err_l = 0; err_a = 0;
    for (int i = 0; i < cnt && i < bd_q.size() && i < rd_q.size(); i++) begin
      if (bd_q[i] !== int'(mem[exp_addr(base, i)])) err_d++;
      if (bl_q[i] !== (i == cnt - 1)) err_l++;
      if (rd_q[i] !== exp_addr(base, i)) err_a++;
    end
    total++;
    if (err_d != 0) begin bad++; $display("FAIL %s data: %0d beats differ from store contents", name, err_d); end
    total++;
    if (err_l != 0) begin bad++; $display("FAIL %s last: %0d beats with wrong smp_last", name, err_l); end
    total++;
    if (err_a != 0) begin bad++; $display("FAIL %s addr: %0d reads at wrong address", name, err_a); end
  endtask

  task automatic run_store(input string name);
    clear_mon();
    res_mode = 1;
    pulse(0, 1, 0);
    wait_done(6000, name);
    res_mode = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, st_read_enable, st_write_enable, st_start_write, st_end_write, st_address,
         st_wdata, smp_data, smp_valid, smp_last, res_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b addr=%0d wdata=%h smp_valid=%b res_ready=%b, all must be 0",
               busy, done, st_address, st_wdata, smp_valid, res_ready);
    end
    total++;
    if ({busy6, done6, re6, we6, sw6, ew6, addr6, wdata6, smp_data6, smp_valid6, smp_last6, res_ready6} !== '0) begin
      bad++;
      $display("FAIL reset_outputs_small: busy=%b addr=%0d smp_valid=%b, all must be 0", busy6, addr6, smp_valid6);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_load_full();
    for (int a = 0; a < N; a++) mem[a] = 16'(a);
    clear_mon();
    rdy_mode = 0;
    pulse(1, 0, 0);
    wait_done(3000, "load_full");
    check_load_beats("load_full", 0, N);
    total++;
    if (first_hs - busy_rise != 1) begin
      bad++; $display("FAIL load_first_latency: %0d cycles after busy, expected 1", first_hs - busy_rise);
    end
    total++;
    if (last_hs - first_hs != N - 1) begin
      bad++; $display("FAIL load_full_rate: span %0d cycles, expected %0d", last_hs - first_hs, N - 1);
    end
    total++;
    if (done_cyc - last_hs != 1 || n_done != 1) begin
      bad++; $display("FAIL load_done: offset %0d count %0d, expected offset 1 count 1", done_cyc - last_hs, n_done);
    end
    total++;
    if (n_excl != 0 || n_idle != 0 || n_start != 0) begin
      bad++; $display("FAIL load_strobes: overlap=%0d idle_addr=%0d start_write=%0d, expected 0", n_excl, n_idle, n_start);
    end
  endtask

  task automatic test_load_stall();
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
    clear_mon();
    rdy_mode = 1;
    pulse(1, 0, 0);
    wait_done(5000, "load_stall");
    rdy_mode = 0;
    check_load_beats("load_stall", 0, N);
    total++;
    if (n_unstable != 0) begin
      bad++; $display("FAIL load_stall_hold: %0d stalled beats changed, expected 0", n_unstable);
    end
  endtask

  task automatic test_store();
    int err;
    run_store("store");
    total++;
    if (n_start != 1) begin bad++; $display("FAIL store_open: start_write seen %0d times, expected 1", n_start); end
    total++;
    if (wa_q.size() != N || n_res_hs != N) begin
      bad++; $display("FAIL store_count: writes=%0d accepted=%0d expected %0d", wa_q.size(), n_res_hs, N);
    end
    err = 0;
    for (int i = 0; i < wa_q.size() && i < N; i++)
      if (wa_q[i] !== exp_addr(0, i) || wd_q[i] !== (16'hA000 + i) % 65536) err++;
    total++;
    if (err != 0) begin bad++; $display("FAIL store_data: %0d writes with wrong address or data", err); end
    total++;
    if (n_end != 1 || n_done != 1 || n_done_end != 1) begin
      bad++; $display("FAIL store_close: end_write=%0d done=%0d together=%0d, expected 1 each", n_end, n_done, n_done_end);
    end
    total++;
    if (n_excl != 0 || n_idle != 0) begin
      bad++; $display("FAIL store_strobes: overlap=%0d idle_addr=%0d, expected 0", n_excl, n_idle);
    end
  endtask

  task automatic test_both_start();
    int late;
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
    clear_mon();
    rdy_mode = 2;
    pulse(1, 1, 0);
    repeat (20) @(posedge clk);
    pulse(0, 1, 0);
    wait_done(5000, "both_start");
    rdy_mode = 0;
    check_load_beats("both_start", 0, N);
    late = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) late++;
    end
    total++;
    if (n_start != 0 || late != 0 || n_done != 1) begin
      bad++; $display("FAIL both_start_priority: start_write=%0d busy_after=%0d done=%0d, expected 0 0 1", n_start, late, n_done);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_mon();
    res_mode = 2;
    pulse(0, 1, 0);
    k = 0;
    while (n_res_hs < 10 && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, st_read_enable, st_write_enable, st_start_write, st_end_write, st_address,
         st_wdata, smp_valid, res_ready} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: busy=%b we=%b addr=%0d wdata=%h res_ready=%b, all must be 0",
               busy, st_write_enable, st_address, st_wdata, res_ready);
    end
    @(posedge clk); #1;
    rst = 0;
    res_mode = 0;
    total++;
    if (n_end != 0 || n_res_hs < 10) begin
      bad++; $display("FAIL reset_mid_abort: end_write=%0d writes=%0d, expected 0 and >=10", n_end, n_res_hs);
    end
    run_store("restart");
    total++;
    if (wa_q.size() != N || wa_q[0] !== 0 || wd_q[0] !== 16'hA000) begin
      bad++; $display("FAIL restart_base: writes=%0d first addr=%0d data=%h, expected %0d 0 a000",
                      wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : -1, (wd_q.size() > 0) ? wd_q[0] : -1, N);
    end
  endtask

  task automatic test_wrap();
    int k, err;
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
    clear_mon();
    rdy_mode = 0;
    pulse(0, 0, 1);
    k = 0;
    while (n_done6 == 0 && k < 50) begin @(negedge clk); k++; end
    total++;
    if (n_done6 != 1 || bd6_q.size() != 4 || rd6_q.size() != 4) begin
      bad++; $display("FAIL wrap_count: done=%0d beats=%0d reads=%0d, expected 1 4 4", n_done6, bd6_q.size(), rd6_q.size());
    end
    err = 0;
    for (int i = 0; i < 4 && i < bd6_q.size() && i < rd6_q.size(); i++)
      if (rd6_q[i] !== exp_addr(1022, i) || bd6_q[i] !== int'(mem[exp_addr(1022, i)]) ||
          bl6_q[i] !== (i == 3)) err++;
    total++;
    if (err != 0) begin
      bad++; $display("FAIL wrap_seq: %0d beats wrong, first addrs %0d %0d", err,
                      (rd6_q.size() > 0) ? rd6_q[0] : -1, (rd6_q.size() > 2) ? rd6_q[2] : -1);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_load_full();
    test_load_stall();
    test_store();
    test_both_start();
    test_reset_mid();
    test_wrap();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
